// File: rtl/fc_weight_streamer_if.sv
// Bundle of the weight write port, burst command and output stream used by
// fc_weight_streamer. The master drives commands/writes; the slave is the store.
interface fc_weight_streamer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int PARALLEL_PE = 4,
  parameter int ROW_AW      = 5,
  parameter int WR_AW       = 7,
  parameter int LEN_W       = 6
) ();
  logic                              wr_en;
  logic [WR_AW-1:0]                  wr_addr;
  logic [DATA_WIDTH-1:0]             wr_data;
  logic                              start;
  logic [ROW_AW-1:0]                 start_row;
  logic [LEN_W-1:0]                  burst_len;
  logic [PARALLEL_PE-1:0]            lane_en;
  logic                              busy;
  logic                              out_valid;
  logic                              out_ready;
  logic [DATA_WIDTH*PARALLEL_PE-1:0] out_data;
  logic                              out_last;
  logic                              done;

  modport master (
    output wr_en, wr_addr, wr_data, start, start_row, burst_len, lane_en, out_ready,
    input  busy, out_valid, out_data, out_last, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, start_row, burst_len, lane_en, out_ready,
    output busy, out_valid, out_data, out_last, done
  );
endinterface

// File: rtl/fc_weight_streamer.sv
// Weight store for the FC stage: word-wise loading, row bursts streamed as
// PARALLEL_PE-wide beats over valid/ready with lane masking and row wrap.
//
// state | meaning
// IDLE  | waiting for a start with non-zero length; first row is fetched on accept
// RUN   | streaming beats until the out_last beat is accepted
module fc_weight_streamer #(
  parameter int DATA_WIDTH  = 32,
  parameter int PARALLEL_PE = 4,
  parameter int FC_ROWS     = 32,
  parameter int ROW_AW      = 5,
  parameter int WR_AW       = 7,
  parameter int LEN_W       = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  fc_weight_streamer_if.slave  bus
);
  localparam int DEPTH = PARALLEL_PE * FC_ROWS;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                            state_q, state_d;
  logic [ROW_AW-1:0]                 row_ptr_q, row_ptr_d;
  logic [LEN_W-1:0]                  remaining_q, remaining_d;
  logic [PARALLEL_PE-1:0]            lane_en_q, lane_en_d;
  logic                              out_valid_q, out_valid_d;
  logic                              out_last_q, out_last_d;
  logic [DATA_WIDTH*PARALLEL_PE-1:0] out_data_q, out_data_d;
  logic                              done_q, done_d;

  logic [DATA_WIDTH-1:0]             mem_q [DEPTH];
  logic [ROW_AW-1:0]                 rd_row;
  logic [PARALLEL_PE-1:0]            rd_lanes;
  logic [LEN_W-1:0]                  rd_cnt;
  logic [DATA_WIDTH*PARALLEL_PE-1:0] rd_vec;
  logic                              accept;

  // No reset on the array: weights survive a controller reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en && (int'(bus.wr_addr) < DEPTH)) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // In IDLE the read is steered by the incoming command so the first beat
  // is registered on the same edge that accepts start.
  assign rd_row   = (state_q == IDLE) ? bus.start_row : row_ptr_q;
  assign rd_lanes = (state_q == IDLE) ? bus.lane_en   : lane_en_q;
  assign rd_cnt   = (state_q == IDLE) ? bus.burst_len : remaining_q;
  assign accept   = out_valid_q & bus.out_ready;

  always_comb begin
    rd_vec = '0;
    for (int k = 0; k < PARALLEL_PE; k++) begin
      if (rd_lanes[k]) begin
        rd_vec[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[WR_AW'(k*FC_ROWS) + WR_AW'(rd_row)];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    row_ptr_d   = row_ptr_q;
    remaining_d = remaining_q;
    lane_en_d   = lane_en_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && (bus.burst_len != '0)) begin
          state_d     = RUN;
          lane_en_d   = bus.lane_en;
          out_data_d  = rd_vec;
          out_valid_d = 1'b1;
          out_last_d  = (rd_cnt == LEN_W'(1));
          row_ptr_d   = rd_row + ROW_AW'(1);
          remaining_d = rd_cnt - LEN_W'(1);
        end
      end
      RUN: begin
        if (accept && out_last_q) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
        end else if ((!out_valid_q || accept) && (remaining_q != '0)) begin
          out_data_d  = rd_vec;
          out_valid_d = 1'b1;
          out_last_d  = (rd_cnt == LEN_W'(1));
          row_ptr_d   = rd_row + ROW_AW'(1);
          remaining_d = rd_cnt - LEN_W'(1);
        end else if (accept) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      row_ptr_q   <= '0;
      remaining_q <= '0;
      lane_en_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_ptr_q   <= row_ptr_d;
      remaining_q <= remaining_d;
      lane_en_q   <= lane_en_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_fc_weight_streamer.sv
// Bench for fc_weight_streamer: directed and randomized bursts checked against
// an array model of the weight store and the burst rules.
module tb_fc_weight_streamer;
  localparam int DW = 32, PE = 4, ROWS = 32, ROW_AW = 5, WR_AW = 7, LEN_W = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fc_weight_streamer_if #(.DATA_WIDTH(DW), .PARALLEL_PE(PE), .ROW_AW(ROW_AW),
                          .WR_AW(WR_AW), .LEN_W(LEN_W)) bus ();

  fc_weight_streamer #(.DATA_WIDTH(DW), .PARALLEL_PE(PE), .FC_ROWS(ROWS),
                       .ROW_AW(ROW_AW), .WR_AW(WR_AW), .LEN_W(LEN_W))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] ref_mem [PE*ROWS];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_beat(input int row, input logic [PE-1:0] lanes);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < PE; k++)
      if (lanes[k]) v[k*DW +: DW] = ref_mem[k*ROWS + (row % ROWS)];
    return v;
  endfunction

  task automatic wr_word(input int addr, input logic [DW-1:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = WR_AW'(addr);
    bus.wr_data = d;
    ref_mem[addr] = d;
  endtask

  task automatic wr_idle();
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // One burst from command to done, with optional stall, random ready,
  // a start poke while running, and a same-edge write at the first fetch.
  task automatic burst(input int row, input int len, input logic [PE-1:0] lanes,
                       input int stall_beat, input int stall_cycles, input bit rand_rdy,
                       input bit poke, input bit coll, input int coll_addr,
                       input logic [DW-1:0] coll_data);
    logic [127:0] exp_q[$];
    int b, stalled, cyc;
    bit rdy;
    b = 0; stalled = 0; cyc = 0;
    for (int i = 0; i < len; i++) exp_q.push_back(exp_beat(row + i, lanes));
    @(negedge clk);
    bus.start     = 1'b1;
    bus.start_row = ROW_AW'(row);
    bus.burst_len = LEN_W'(len);
    bus.lane_en   = lanes;
    bus.out_ready = 1'b0;
    if (coll) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = WR_AW'(coll_addr);
      bus.wr_data = coll_data;
      ref_mem[coll_addr] = coll_data;
    end
    while (b < len && cyc < len*10 + 20) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      if (poke && cyc == 2) begin
        bus.start     = 1'b1;
        bus.start_row = ROW_AW'(row + 7);
        bus.burst_len = LEN_W'(3);
        bus.lane_en   = ~lanes;
      end
      chk("busy_run", 128'(bus.busy), 128'(1'b1));
      chk("valid_run", 128'(bus.out_valid), 128'(1'b1));
      chk($sformatf("data_beat%0d", b), bus.out_data, exp_q[b]);
      chk($sformatf("last_beat%0d", b), 128'(bus.out_last), 128'(b == len - 1));
      rdy = 1'b1;
      if (b == stall_beat && stalled < stall_cycles) begin
        rdy = 1'b0;
        stalled++;
      end else if (rand_rdy) begin
        rdy = ($urandom_range(0, 2) != 0);
      end
      if (rdy) b++;
      bus.out_ready = rdy;
    end
    chk("beats_delivered", 128'(b), 128'(len));
    @(negedge clk);
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    chk("done_pulse", 128'(bus.done), 128'(1'b1));
    chk("busy_after", 128'(bus.busy), 128'(1'b0));
    chk("valid_after", 128'(bus.out_valid), 128'(1'b0));
    @(negedge clk);
    chk("done_single", 128'(bus.done), 128'(1'b0));
  endtask

  initial begin
    logic [127:0] exp_v;
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.start_row = '0; bus.burst_len = '0; bus.lane_en = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(bus.busy), 128'(1'b0));
    chk("rst_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("rst_data", bus.out_data, 128'(0));
    chk("rst_last", 128'(bus.out_last), 128'(1'b0));
    chk("rst_done", 128'(bus.done), 128'(1'b0));
    reset = 1'b0;

    // Load {k,r} and stream the full depth.
    for (int k = 0; k < PE; k++)
      for (int r = 0; r < ROWS; r++)
        wr_word(k*ROWS + r, DW'((k << 16) | r));
    wr_idle();
    burst(0, 32, 4'hF, -1, 0, 1'b0, 1'b0, 1'b0, 0, '0);

    // Wrap with lanes 1 and 3 masked.
    burst(30, 4, 4'b0101, -1, 0, 1'b0, 1'b0, 1'b0, 0, '0);

    // Random contents, then backpressure on beat 2.
    for (int a = 0; a < PE*ROWS; a++) wr_word(a, DW'($urandom));
    wr_idle();
    burst(3, 5, 4'hF, 2, 3, 1'b0, 1'b0, 1'b0, 0, '0);

    // Collision at row 5 lane 0, then re-read.
    burst(5, 1, 4'hF, -1, 0, 1'b0, 1'b0, 1'b1, 5, 32'h0000_DEAD);
    burst(5, 2, 4'hF, -1, 0, 1'b0, 1'b0, 1'b0, 0, '0);

    // Zero-length start is a no-op.
    @(negedge clk);
    bus.start = 1'b1; bus.start_row = 5'd4; bus.burst_len = '0; bus.lane_en = 4'hF;
    @(negedge clk);
    bus.start = 1'b0;
    chk("len0_busy", 128'(bus.busy), 128'(1'b0));
    chk("len0_valid", 128'(bus.out_valid), 128'(1'b0));
    @(negedge clk);
    chk("len0_done", 128'(bus.done), 128'(1'b0));

    // Start while running is ignored.
    burst(10, 6, 4'b1011, -1, 0, 1'b0, 1'b1, 1'b0, 0, '0);

    // Reset at beat 3 of 8.
    @(negedge clk);
    bus.start = 1'b1; bus.start_row = 5'd12; bus.burst_len = LEN_W'(8); bus.lane_en = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.out_ready = 1'b1;
      exp_v = exp_beat(12 + i, 4'hF);
      chk($sformatf("rstmid_beat%0d", i), bus.out_data, exp_v);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b0;
    chk("rstmid_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("rstmid_busy", 128'(bus.busy), 128'(1'b0));
    chk("rstmid_data", bus.out_data, 128'(0));
    chk("rstmid_last", 128'(bus.out_last), 128'(1'b0));
    chk("rstmid_done0", 128'(bus.done), 128'(1'b0));
    @(negedge clk);
    chk("rstmid_done1", 128'(bus.done), 128'(1'b0));
    chk("rstmid_busy1", 128'(bus.busy), 128'(1'b0));

    // Longer than depth: rows repeat.
    burst(0, 40, 4'hF, -1, 0, 1'b0, 1'b0, 1'b0, 0, '0);

    // Random bursts with random backpressure.
    for (int n = 0; n < 8; n++)
      burst($urandom_range(0, ROWS-1), $urandom_range(1, 40), PE'($urandom),
            -1, 0, 1'b1, 1'b0, 1'b0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
